// File: rtl/sram_pkg.sv
// Shared types and constants for the dual-port SRAM block.
package sram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int RD_LAT_1 = 1;
  localparam int RD_LAT_2 = 2;
  localparam int BYTE_W   = 8;

endpackage

// File: rtl/sram_dp_array.sv
// Storage array: one byte-enabled write port and one registered read port.
module sram_dp_array
  import sram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W/BYTE_W-1:0] wbe,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [DATA_W-1:0]        rdata
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Byte-enabled write into the array
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) begin
          mem[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read word is captured before the same-edge write lands (old data on collision)
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_dp.sv
// Dual-port SRAM with byte enables, clear sweep and 1/2-cycle read latency.
// Optional feature: define SRAM_DP_BYPASS_EN for write-to-read forwarding on address collision.
module sram_dp
  import sram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CS_N,
  input  logic                     WR_N,
  input  logic [ADDR_W-1:0]        WRADDR,
  input  logic [DATA_W/8-1:0]      WRBE,
  input  logic [DATA_W-1:0]        WRDATA,
  input  logic                     RD_N,
  input  logic [ADDR_W-1:0]        RDADDR,
  input  logic                     CLR,
  output logic [DATA_W-1:0]        RDDATA,
  output logic                     RDVALID,
  output logic                     BUSY
);

  localparam int NB = DATA_W / BYTE_W;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   cnt_inc_s;
  logic              busy_q, busy_d;
  logic              v1_q, v1_d;
  logic [NB-1:0]     bmask_q, bmask_d;
  logic [DATA_W-1:0] bdata_q, bdata_d;

  logic              run_s, wr_acc_s, rd_acc_s;
  logic              arr_we_s;
  logic [ADDR_W-1:0] arr_waddr_s;
  logic [NB-1:0]     arr_wbe_s;
  logic [DATA_W-1:0] arr_wdata_s;
  logic [DATA_W-1:0] arr_rdata_s;
  logic [DATA_W-1:0] stage1_s;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     sel
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (sel[b]) begin
        res[b*BYTE_W +: BYTE_W] = new_w[b*BYTE_W +: BYTE_W];
      end else begin
        res[b*BYTE_W +: BYTE_W] = old_w[b*BYTE_W +: BYTE_W];
      end
    end
    return res;
  endfunction

  // Sweep FSM; the extra counter bit flags completion instead of wrapping
  always_comb begin
    run_s     = (state_q == ST_RUN);
    wr_acc_s  = run_s & ~CS_N & ~WR_N;
    rd_acc_s  = run_s & ~CS_N & ~RD_N;
    cnt_inc_s = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    state_d   = state_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (CLR) begin
          cnt_d = {(ADDR_W+1){1'b0}};
        end else if (cnt_inc_s[ADDR_W]) begin
          state_d = ST_RUN;
          cnt_d   = {(ADDR_W+1){1'b0}};
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_RUN: begin
        if (CLR) begin
          state_d = ST_INIT;
          cnt_d   = {(ADDR_W+1){1'b0}};
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = {(ADDR_W+1){1'b0}};
      end
    endcase
    busy_d = (state_d == ST_INIT);
  end

  // Clear mux: the sweep owns the write port whenever the array is not running
  always_comb begin
    arr_we_s    = ~run_s | wr_acc_s;
    arr_waddr_s = WRADDR;
    arr_wbe_s   = WRBE;
    arr_wdata_s = WRDATA;
    if (!run_s) begin
      arr_waddr_s = cnt_q[ADDR_W-1:0];
      arr_wbe_s   = {NB{1'b1}};
      arr_wdata_s = {DATA_W{1'b0}};
    end else begin
      arr_waddr_s = WRADDR;
      arr_wbe_s   = WRBE;
      arr_wdata_s = WRDATA;
    end
  end

  // Capture the collision mask and write data alongside each accepted read
  always_comb begin
    v1_d    = rd_acc_s;
    bdata_d = WRDATA;
`ifdef SRAM_DP_BYPASS_EN
    if (wr_acc_s && rd_acc_s && (WRADDR == RDADDR)) begin
      bmask_d = WRBE;
    end else begin
      bmask_d = {NB{1'b0}};
    end
`else
    bmask_d = {NB{1'b0}};
`endif
  end

  // Control and first read-stage registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_INIT;
      cnt_q   <= {(ADDR_W+1){1'b0}};
      busy_q  <= 1'b1;
      v1_q    <= 1'b0;
      bmask_q <= {NB{1'b0}};
      bdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      v1_q    <= v1_d;
      bmask_q <= bmask_d;
      bdata_q <= bdata_d;
    end
  end

  sram_dp_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (CLK),
    .we    (arr_we_s),
    .waddr (arr_waddr_s),
    .wbe   (arr_wbe_s),
    .wdata (arr_wdata_s),
    .re    (rd_acc_s),
    .raddr (RDADDR),
    .rdata (arr_rdata_s)
  );

  assign stage1_s = v1_q ? merge_bytes(arr_rdata_s, bdata_q, bmask_q) : {DATA_W{1'b0}};
  assign BUSY     = busy_q;

  generate
    if (RD_LAT == RD_LAT_2) begin : g_lat2
      logic              v2_q, v2_d;
      logic [DATA_W-1:0] d2_q, d2_d;

      // Second pipeline stage input
      always_comb begin
        v2_d = v1_q;
        d2_d = stage1_s;
      end

      // Second pipeline stage register
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          v2_q <= 1'b0;
          d2_q <= {DATA_W{1'b0}};
        end else begin
          v2_q <= v2_d;
          d2_q <= d2_d;
        end
      end

      assign RDVALID = v2_q;
      assign RDDATA  = d2_q;
    end else begin : g_lat1
      assign RDVALID = v1_q;
      assign RDDATA  = stage1_s;
    end
  endgenerate

endmodule

// File: tb/tb_sram_dp.sv
// Scoreboard bench for sram_dp: two instances (RD_LAT 1 and 2) share stimulus.
module tb_sram_dp;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CS_N = 1'b1, WR_N = 1'b1, RD_N = 1'b1, CLR = 1'b0;
  logic [AW-1:0] WRADDR = '0, RDADDR = '0;
  logic [1:0]    WRBE = '0;
  logic [DW-1:0] WRDATA = '0;

  logic [DW-1:0] rddata1, rddata2;
  logic          rdvalid1, rdvalid2, busy1, busy2;

  always #5 CLK = ~CLK;

  sram_dp #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_lat1 (
    .CLK(CLK), .RST(RST), .CS_N(CS_N), .WR_N(WR_N), .WRADDR(WRADDR), .WRBE(WRBE),
    .WRDATA(WRDATA), .RD_N(RD_N), .RDADDR(RDADDR), .CLR(CLR),
    .RDDATA(rddata1), .RDVALID(rdvalid1), .BUSY(busy1));

  sram_dp #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) u_lat2 (
    .CLK(CLK), .RST(RST), .CS_N(CS_N), .WR_N(WR_N), .WRADDR(WRADDR), .WRBE(WRBE),
    .WRDATA(WRDATA), .RD_N(RD_N), .RDADDR(RDADDR), .CLR(CLR),
    .RDDATA(rddata2), .RDVALID(rdvalid2), .BUSY(busy2));

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q1[$];
  exp_t          q2[$];
  logic [DW-1:0] mem [DEPTH];
  int            busy_left = DEPTH;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] last1 = '0, last2 = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor one port: every cycle compare BUSY, and pop/compare on RDVALID
  task automatic mon_port(input int idx, input logic v, input logic [DW-1:0] d, input logic b);
    exp_t e;
    bit   have;
    check($sformatf("busy_lat%0d", idx), b, busy_left > 0);
    if (v) begin
      have = 1'b0;
      if (idx == 1 && q1.size() > 0) begin
        e = q1.pop_front(); have = 1'b1;
      end else if (idx == 2 && q2.size() > 0) begin
        e = q2.pop_front(); have = 1'b1;
      end
      if (!have) begin
        checks++; errors++;
        $display("FAIL unexpected_rdvalid_lat%0d got data %h expected no read (cycle %0d)", idx, d, cyc);
      end else begin
        check($sformatf("rddata_lat%0d", idx), d, e.data);
        check($sformatf("rd_latency_lat%0d", idx), cyc, e.due);
        if (idx == 1) last1 = d; else last2 = d;
      end
    end else begin
      check($sformatf("rddata_idle_lat%0d", idx), d, '0);
      if (idx == 1 && q1.size() > 0 && q1[0].due < cyc) begin
        e = q1.pop_front(); checks++; errors++;
        $display("FAIL missing_rdvalid_lat1 got none expected %h due %0d", e.data, e.due);
      end
      if (idx == 2 && q2.size() > 0 && q2[0].due < cyc) begin
        e = q2.pop_front(); checks++; errors++;
        $display("FAIL missing_rdvalid_lat2 got none expected %h due %0d", e.data, e.due);
      end
    end
  endtask

  // Output monitor, sampled 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      mon_port(1, rdvalid1, rddata1, busy1);
      mon_port(2, rdvalid2, rddata2, busy2);
    end
  end

  // Drive one cycle of inputs (at a falling edge) and advance the reference model
  task automatic step(input logic cs_n, input logic wr_n, input logic rd_n, input logic clr,
                      input logic [AW-1:0] wa, input logic [1:0] be, input logic [DW-1:0] wd,
                      input logic [AW-1:0] ra);
    logic [DW-1:0] exp_v;
    logic [DW-1:0] m;
    CS_N = cs_n; WR_N = wr_n; RD_N = rd_n; CLR = clr;
    WRADDR = wa; WRBE = be; WRDATA = wd; RDADDR = ra;
    m = {{8{be[1]}}, {8{be[0]}}};
    if (busy_left > 0) begin
      if (clr) busy_left = DEPTH;
      else     busy_left = busy_left - 1;
    end else begin
      if (!cs_n && !rd_n) begin
        exp_v = mem[ra];
`ifdef SRAM_DP_BYPASS_EN
        if (!wr_n && wa == ra) exp_v = (exp_v & ~m) | (wd & m);
`endif
        q1.push_back('{exp_v, cyc + 1});
        q2.push_back('{exp_v, cyc + 2});
      end
      if (!cs_n && !wr_n) mem[wa] = (mem[wa] & ~m) | (wd & m);
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        busy_left = DEPTH;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, a);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [1:0] be, input logic [DW-1:0] d);
    step(1'b0, 1'b0, 1'b1, 1'b0, a, be, d, '0);
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    CS_N = 1'b1; WR_N = 1'b1; RD_N = 1'b1; CLR = 1'b0;
    q1.delete(); q2.delete();
    busy_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (n) begin @(posedge CLK); @(negedge CLK); end
    RST = 1'b0;
  endtask

  // Count cycles with BUSY high; optionally throw random requests at the DUT meanwhile
  task automatic count_busy(input bit noise, output int n);
    n = 0;
    while (busy1 && n < 100) begin
      if (noise)
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
             AW'($urandom_range(0, DEPTH-1)), 2'($urandom_range(0, 3)), DW'($urandom),
             AW'($urandom_range(0, DEPTH-1)));
      else
        idle(1);
      n++;
    end
  endtask

  initial begin
    int n;
    @(negedge CLK);
    do_reset(2);

    count_busy(1'b0, n);
    check("busy_len_after_reset", n, DEPTH);
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));
    idle(3);

    wr(4'h3, 2'b11, 16'hA5C3);
    rd(4'h3);
    idle(3);
    check("full_write_lat1", last1, 16'hA5C3);
    check("full_write_lat2", last2, 16'hA5C3);

    wr(4'h3, 2'b01, 16'h1234);
    rd(4'h3);
    idle(3);
    check("byte_write_lat1", last1, 16'hA534);
    check("byte_write_lat2", last2, 16'hA534);

    wr(4'h7, 2'b11, 16'h1111);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 2'b11, 16'hBEEF, 4'h7);
    idle(3);
`ifdef SRAM_DP_BYPASS_EN
    check("collision_lat1", last1, 16'hBEEF);
    check("collision_lat2", last2, 16'hBEEF);
`else
    check("collision_lat1", last1, 16'h1111);
    check("collision_lat2", last2, 16'h1111);
`endif
    rd(4'h7);
    idle(3);

    rd(4'h7);
    rd(4'h3);
    step(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, '0, 4'h3);
    count_busy(1'b1, n);
    check("busy_len_after_clr", n, DEPTH);
    check("inflight_old_lat1", last1, 16'hA534);
    check("inflight_old_lat2", last2, 16'hA534);
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));
    idle(3);

    do_reset(2);
    idle(5);
    do_reset(1);
    count_busy(1'b0, n);
    check("busy_len_after_midsweep_rst", n, DEPTH);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) == 0), AW'($urandom_range(0, DEPTH-1)),
           2'($urandom_range(0, 3)), DW'($urandom), AW'($urandom_range(0, DEPTH-1)));
    end
    idle(4);
    check("drained_lat1", q1.size(), 0);
    check("drained_lat2", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_dp.md
SRAM_DP -- requirements
Module: sram_dp

Interface
REQ-001 Parameter DATA_W, default 16, shall set the data width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 Parameter ADDR_W, default 10, shall set the address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter RD_LAT, default 1, shall set the read latency in cycles; legal values are 1 and 2.
REQ-004 CLK  in  1  shall be the single clock; all state changes on its rising edge.
REQ-005 RST  in  1  shall be the reset: asynchronous, active-high.
REQ-006 CS_N  in  1  shall be the active-low chip select gating both ports.
REQ-007 WR_N  in  1  shall be the active-low write strobe.
REQ-008 WRADDR  in  ADDR_W  shall be the write address.
REQ-009 WRBE  in  DATA_W/8  shall be the byte enables (1 = write byte).
REQ-010 WRDATA  in  DATA_W  shall be the write data.
REQ-011 RD_N  in  1  shall be the active-low read strobe.
REQ-012 RDADDR  in  ADDR_W  shall be the read address.
REQ-013 CLR  in  1  shall be a single-cycle request to re-zero the whole array.
REQ-014 RDDATA  out  DATA_W  shall be the read data.
REQ-015 RDVALID  out  1  shall qualify RDDATA for exactly one cycle per accepted read.
REQ-016 BUSY  out  1  shall be high while the array is being cleared.

Function
REQ-017 FSM states INIT and RUN; RST forces INIT with clear counter 0.
REQ-018 In INIT, one word shall be zeroed per cycle at the counter address; after address DEPTH-1 is written the next state shall be RUN; BUSY=1 throughout INIT.
REQ-019 Clear duration shall be exactly DEPTH cycles from RST deassertion or from CLR sampled.
REQ-020 In RUN, a write shall occur when CS_N=0 and WR_N=0; only bytes with WRBE=1 are updated.
REQ-021 In RUN, a read shall be accepted when CS_N=0 and RD_N=0; read and write may be accepted in the same cycle.
REQ-022 An accepted read shall produce RDDATA and RDVALID=1 exactly RD_LAT cycles later; back-to-back reads shall be accepted every cycle.
REQ-023 When RDVALID=0, RDDATA shall be all zeros.
REQ-024 In INIT, all write and read requests shall be ignored (no array update, no RDVALID).
REQ-025 CLR sampled high in RUN shall enter INIT with counter 0 on the next cycle; CLR in INIT shall restart the counter at 0.
REQ-026 Reads in the pipeline when CLR is sampled shall still complete with their pre-clear data.
REQ-027 Address arithmetic shall be unsigned ADDR_W bits; the clear counter shall be ADDR_W+1 bits to detect completion without wrap.

Reset
REQ-028 RST shall asynchronously force state INIT, counter 0, BUSY=1, RDVALID=0, RDDATA=0 and all read-pipeline valid bits 0.
REQ-029 Array contents shall not be reset directly; they are zeroed by the INIT sweep.
REQ-030 RST asserted mid-sweep or mid-read shall discard all in-flight reads and restart the sweep at 0.

Configuration
REQ-031 Macro SRAM_DP_BYPASS_EN defined: a read and write to the same address in the same cycle shall return the new data for bytes with WRBE=1 and old data otherwise.
REQ-032 SRAM_DP_BYPASS_EN undefined: such a collision shall return the entire old word.

Structure
REQ-033 A shared package sram_pkg shall hold the FSM state typedef (INIT, RUN) and the legal RD_LAT constants.
REQ-034 One sub-module sram_dp_array shall contain the storage with byte-enable write and registered read; the FSM, clear mux, bypass and latency pipeline shall be in sram_dp.

Verification
REQ-035 RST pulse, ADDR_W=4 -> BUSY=1 for exactly 16 cycles after release; all 16 reads then return 0x0000.
REQ-036 Write 0xA5C3 to 0x3 with WRBE=2'b11, then read 0x3 at RD_LAT=1 and RD_LAT=2 -> 0xA5C3 with RDVALID after 1 and 2 cycles respectively.
REQ-037 Over 0xA5C3, write 0x1234 with WRBE=2'b01 -> read returns 0xA534.
REQ-038 Same-cycle write 0xBEEF and read at 0x7 holding 0x1111 -> 0xBEEF with SRAM_DP_BYPASS_EN, 0x1111 without.
REQ-039 CLR during a read stream -> in-flight reads return old data; BUSY=1 for DEPTH cycles; requests made during INIT produce no RDVALID and no array change.
REQ-040 RST asserted at counter 5 of the sweep -> sweep restarts at 0; BUSY=1 for a full DEPTH cycles after release.
